// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the memory responder state encoding.
package cpu_pkg;

   localparam int CPU_DATA_W = 8;
   localparam int CPU_ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word store: synchronous write, combinational read, contents survive reset.
module mem_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
   end

   assign dout = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the CPU read/write strobe interface with programmable wait states.
// Optional write protection of the low address range is enabled by defining MEM_WRITE_PROTECT_EN.
//
//   state | meaning
//   IDLE  | waiting for a read or write strobe
//   WAIT  | request latched, counting down wait states
//   ACK   | access done, ready (and werr) high for this one cycle
module mem_responder
   import cpu_pkg::*;
#(
   parameter int DATA_W      = CPU_DATA_W,
   parameter int ADDR_W      = CPU_ADDR_W,
   parameter int WAIT_CYCLES = 2,
   parameter int PROTECT_TOP = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              werr
);

`ifdef MEM_WRITE_PROTECT_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   mem_state_t        state_q;
   logic [3:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wr_q;
   logic [DATA_W-1:0] rdata_q;
   logic              ready_q;
   logic              werr_q;

   logic              req;
   logic              go_ack;
   logic              acc_wr;
   logic              acc_prot;
   logic              mem_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_din;
   logic [DATA_W-1:0] mem_dout;

   assign req = read | write;

   // With zero wait states the access happens on the accept edge, so the array
   // must see the live request rather than the not-yet-latched copy.
   assign go_ack   = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd0));
   assign acc_addr = (state_q == IDLE) ? addr  : addr_q;
   assign acc_din  = (state_q == IDLE) ? wdata : wdata_q;
   assign acc_wr   = (state_q == IDLE) ? write : wr_q;
   assign acc_prot = PROT_EN && (int'(acc_addr) < PROTECT_TOP);
   assign mem_we   = go_ack && acc_wr && !acc_prot;

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk  (clk),
      .we   (mem_we),
      .addr (acc_addr),
      .din  (acc_din),
      .dout (mem_dout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         werr_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         werr_q  <= 1'b0;
         if (go_ack) begin
            ready_q <= 1'b1;
            werr_q  <= acc_wr && acc_prot;
            if (!acc_wr) rdata_q <= mem_dout;
         end
         case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  wr_q    <= write;
                  cnt_q   <= CNT_LOAD;
                  state_q <= (WAIT_CYCLES == 0) ? ACK : WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) state_q <= ACK;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            ACK:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign busy  = (state_q != IDLE);
   assign werr  = werr_q;

endmodule
